// File: rtl/seller_multi.sv
// seller_multi: two-item vending controller with coin credit, change and cancel refund.
// Optional per-item sales counters are enabled with SELLER_SALES_CNT_EN.
module seller_multi #(
    parameter int CREDIT_W = 4,
    parameter int PRICE0   = 3,
    parameter int PRICE1   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d1,
    input  logic                d2,
    input  logic                d3,
    input  logic                sel,
    input  logic                cancel,
    output logic                vend,
    output logic                vend_item,
    output logic [CREDIT_W-1:0] change,
    output logic                refund_vld,
    output logic [CREDIT_W-1:0] refund,
    output logic [CREDIT_W-1:0] credit,
    output logic [7:0]          sold0,
    output logic [7:0]          sold1
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    state_t state, state_nx;
    logic [CREDIT_W:0] coin_sum, next_credit, price;
    logic [CREDIT_W-1:0] credit_nx, change_nx, refund_nx;
    logic can_vend, vend_nx, vend_item_nx, refund_vld_nx;
    always_comb begin
        coin_sum = (CREDIT_W+1)'({d3, d2, d1});
        // credit is only ever held in COLLECT, so DONE restarts from zero
        next_credit = (state == COLLECT ? {1'b0, credit} : '0) + coin_sum;
        price = sel ? (CREDIT_W+1)'(PRICE1) : (CREDIT_W+1)'(PRICE0);
        can_vend = next_credit >= price;
        vend_nx = !cancel && can_vend;
        vend_item_nx = vend_nx && sel;
        change_nx = vend_nx ? CREDIT_W'(next_credit - price) : '0;
        refund_vld_nx = cancel && next_credit != '0;
        refund_nx = cancel ? CREDIT_W'(next_credit) : '0;
        credit_nx = (cancel || can_vend) ? '0 : CREDIT_W'(next_credit);
        state_nx = (vend_nx || refund_vld_nx) ? DONE : (credit_nx != '0 ? COLLECT : IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            credit     <= '0;
            vend       <= 1'b0;
            vend_item  <= 1'b0;
            change     <= '0;
            refund_vld <= 1'b0;
            refund     <= '0;
        end else begin
            state      <= state_nx;
            credit     <= credit_nx;
            vend       <= vend_nx;
            vend_item  <= vend_item_nx;
            change     <= change_nx;
            refund_vld <= refund_vld_nx;
            refund     <= refund_nx;
        end
    end
`ifdef SELLER_SALES_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            sold0 <= '0;
            sold1 <= '0;
        end else begin
            if (vend_nx && !sel && sold0 != 8'hff) sold0 <= sold0 + 8'd1;
            if (vend_nx && sel && sold1 != 8'hff) sold1 <= sold1 + 8'd1;
        end
    end
`else
    assign sold0 = '0;
    assign sold1 = '0;
`endif
endmodule

// File: tb/tb_seller_multi.sv
// tb_seller_multi: directed and random checks of seller_multi against a credit-level model.
module tb_seller_multi;
    localparam int W = 4;
    localparam int P0 = 3;
    localparam int P1 = 5;
`ifdef SELLER_SALES_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, sel = 1'b0, cancel = 1'b0;
    logic vend, vend_item, refund_vld;
    logic [W-1:0] change, refund, credit;
    logic [7:0] sold0, sold1;
    int n_checks = 0, n_fails = 0;
    int m_credit = 0, m_sold0 = 0, m_sold1 = 0;
    int e_vend, e_item, e_change, e_rv, e_refund;

    seller_multi #(.CREDIT_W(W), .PRICE0(P0), .PRICE1(P1)) dut (
        .clk(clk), .rst(rst), .d1(d1), .d2(d2), .d3(d3), .sel(sel), .cancel(cancel),
        .vend(vend), .vend_item(vend_item), .change(change), .refund_vld(refund_vld),
        .refund(refund), .credit(credit), .sold0(sold0), .sold1(sold1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: credit is a plain integer; cancel, then purchase, then accumulate.
    task automatic model();
        int total, price;
        e_vend = 0; e_item = 0; e_change = 0; e_rv = 0; e_refund = 0;
        if (!rst) begin
            m_credit = 0; m_sold0 = 0; m_sold1 = 0;
        end else begin
            total = m_credit + (d1 ? 1 : 0) + (d2 ? 2 : 0) + (d3 ? 4 : 0);
            price = sel ? P1 : P0;
            if (cancel) begin
                e_refund = total;
                e_rv = (total != 0) ? 1 : 0;
                m_credit = 0;
            end else if (total >= price) begin
                e_vend = 1;
                e_item = sel ? 1 : 0;
                e_change = total - price;
                m_credit = 0;
                if (CNT_EN && !sel && m_sold0 < 255) m_sold0++;
                if (CNT_EN && sel && m_sold1 < 255) m_sold1++;
            end else begin
                m_credit = total;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".vend"}, 32'(vend), 32'(e_vend));
        chk({tag, ".vend_item"}, 32'(vend_item), 32'(e_item));
        chk({tag, ".change"}, 32'(change), 32'(e_change));
        chk({tag, ".refund_vld"}, 32'(refund_vld), 32'(e_rv));
        chk({tag, ".refund"}, 32'(refund), 32'(e_refund));
        chk({tag, ".credit"}, 32'(credit), 32'(m_credit));
        chk({tag, ".sold0"}, 32'(sold0), 32'(m_sold0));
        chk({tag, ".sold1"}, 32'(sold1), 32'(m_sold1));
    endtask

    task automatic step(input string tag, input logic r, input logic a, input logic b,
                        input logic c, input logic s, input logic cn);
        @(negedge clk);
        rst = r; d1 = a; d2 = b; d3 = c; sel = s; cancel = cn;
        @(posedge clk);
        model();
        #1 check_all(tag);
    endtask

    initial begin
        step("reset0", 0, 0, 0, 0, 0, 0);
        step("reset1", 0, 1, 1, 1, 1, 0);
        step("idle", 1, 0, 0, 0, 0, 0);
        step("single1", 1, 1, 0, 0, 0, 0);
        step("single2", 1, 1, 0, 0, 0, 0);
        step("single3", 1, 1, 0, 0, 0, 0);
        chk("plan.vend_item0", 32'(vend), 32'd1);
        step("after_vend", 1, 0, 0, 0, 0, 0);
        step("overpay", 1, 1, 1, 1, 1, 0);
        chk("plan.change2", 32'(change), 32'd2);
        step("cancel_d2", 1, 0, 1, 0, 0, 0);
        step("cancel_d1", 1, 1, 0, 0, 0, 1);
        chk("plan.refund3", 32'(refund), 32'd3);
        step("cancel_zero", 1, 0, 0, 0, 0, 1);
        step("cancel_zero2", 1, 0, 0, 0, 0, 1);
        step("sel1_d3", 1, 0, 0, 1, 1, 0);
        step("sel_switch", 1, 0, 0, 0, 0, 0);
        chk("plan.switch_change1", 32'(change), 32'd1);
        step("done_d3", 1, 0, 0, 1, 0, 0);
        chk("plan.b2b_vend", 32'(vend), 32'd1);
        step("rst_pre", 1, 1, 0, 0, 1, 0);
        step("rst_mid", 0, 0, 0, 0, 1, 0);
        step("rst_post", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            step("rand", (r[15:0] != 0), r[16], r[17], r[18], r[19], (r[23:20] == 0));
        end
        for (int i = 0; i < 260; i++) step("sat0", 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("sat1", 1, 0, 1, 1, 1, 0);
        step("coll_pre", 1, 0, 1, 0, 1, 0);
        step("coll_rst", 0, 0, 0, 0, 1, 0);
        chk("plan.rst_refund", 32'(refund_vld), 32'd0);
        step("coll_after", 1, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/seller_multi.md
# seller_multi

Parametrised two-item vending controller; successor to the single-price seller. Sums the coin pulses on every cycle into a credit register and vends the item chosen on `sel` once credit covers its price. Change is returned in the same pulse as the vend, and a cancel input refunds all credit. It sits between the coin-acceptor front end and the dispense/change-return actuators.

## Interface
Parameters:
- `CREDIT_W`, 4: width of the credit, change and refund paths. Must satisfy 2^CREDIT_W-1 >= max(PRICE0,PRICE1)+6.
- `PRICE0`, 3: price of item 0, in coin units.
- `PRICE1`, 5: price of item 1, in coin units. Both prices must be 1..2^CREDIT_W-1.

Ports:
- `clk`  input  1  clock. One clock domain; all logic is on its rising edge.
- `rst`  input  1  reset. Synchronous and active-low.
- `d1`  input  1  coin pulse worth 1 unit.
- `d2`  input  1  coin pulse worth 2 units.
- `d3`  input  1  coin pulse worth 4 units.
- `sel`  input  1  item select. 0 selects PRICE0, 1 selects PRICE1. Sampled every cycle.
- `cancel`  input  1  refund request.
- `vend`  output  1  one-cycle dispense pulse.
- `vend_item`  output  1  the item dispensed. Valid while `vend`=1.
- `change`  output  CREDIT_W  change amount. Valid while `vend`=1, otherwise 0.
- `refund_vld`  output  1  one-cycle refund pulse.
- `refund`  output  CREDIT_W  refund amount. Valid while `refund_vld`=1, otherwise 0.
- `credit`  output  CREDIT_W  current credit. Status output.
- `sold0`  output  8  count of item-0 sales (see Configuration).
- `sold1`  output  8  count of item-1 sales (see Configuration).

## Operation
- `coin_sum` = d1·1 + d2·2 + d3·4.
  - Simultaneous coins are all accepted; the maximum is 7 per cycle.
- `next_credit` = `credit` + `coin_sum`, computed at CREDIT_W+1 bits. It cannot overflow while the parameter rule holds.
- `price` = `sel` ? PRICE1 : PRICE0, using `sel` of the current cycle. Changing `sel` mid-collection re-targets the purchase.
- FSM states:
  - IDLE: credit is 0.
  - COLLECT: 0 < credit < price.
  - DONE: the one cycle after a vend or a refund; credit is 0.
- Each cycle, in any state, the first matching rule below applies:
  1. `cancel`=1:
     - `refund` <= `next_credit`.
     - `refund_vld` <= 1 only if `next_credit` != 0.
     - `credit` <= 0.
     - State goes to DONE if a refund was issued, else IDLE.
     - Cancel beats vend: coins arriving with cancel are refunded too.
  2. `next_credit` >= `price`:
     - `vend` <= 1, `vend_item` <= `sel`.
     - `change` <= `next_credit` - `price`.
     - `credit` <= 0, state goes to DONE.
  3. Otherwise:
     - `credit` <= `next_credit`.
     - State goes to COLLECT if `next_credit` != 0, else IDLE.
- DONE does not block the next purchase.
  - Coins arriving in DONE start new credit from 0.
  - A vend can fire again immediately.
- `vend` and `refund_vld` are never high in the same cycle.

## Timing
- Reset (`rst`=0 at a clock edge) forces state IDLE and sets `credit`, `vend`, `vend_item`, `change`, `refund_vld`, `refund`, `sold0` and `sold1` to 0.
- Reset during COLLECT discards the credit with no refund pulse.
- All outputs are registered.
- Latency:
  - A coin that completes the price at edge N shows `vend`/`change` during cycle N+1.
  - A cancel sampled at edge N shows `refund_vld` during cycle N+1.
  - `credit` reflects coins one cycle after they are sampled.
- Pulse outputs stay high for exactly one cycle unless the triggering condition recurs on the next edge.

## Configuration
- Macro: `SELLER_SALES_CNT_EN`.
- Defined:
  - `sold0` and `sold1` increment on every vend of their item.
  - They saturate at 255 and clear only on reset.
- Undefined:
  - Counter logic is compiled out and `sold0`/`sold1` are tied to 0.
  - The ports remain, so the port list is identical in both builds.

## Test plan
- Item 0 by single coins: PRICE0=3, sel=0, d1 on three consecutive cycles. Expect credit 1, 2, then `vend`=1, `vend_item`=0, `change`=0 in the following cycle, and credit back to 0.
- Overpay item 1 with simultaneous coins: sel=1, d1+d2+d3 in one cycle (sum 7). Expect `vend`=1, `vend_item`=1, `change`=2 in the next cycle.
- Cancel:
  - Insert d2 (credit 2), then cancel with d1 in the same cycle. Expect `refund_vld`=1, `refund`=3, no `vend`, credit 0.
  - Cancel with credit 0 and no coins. Expect no `refund_vld`.
- Sel switch and back-to-back purchase:
  - sel=1, d3 (credit 4), then switch sel to 0 with no coin. Expect a vend of item 0 with change 1.
  - d3 in the DONE cycle. Expect a second vend with change 1 in the next cycle.
- Reset and counters (macro defined):
  - 256 item-0 vends. Expect `sold0` saturates at 255.
  - `rst`=0 mid-COLLECT. Expect all outputs 0 after the edge and no refund pulse.
  - With the macro undefined, `sold0`/`sold1` stay 0 throughout.
